object_draw_engine: RTL and testbench

//  Pixel-generation datapath driven by the game draw-sequencing FSM.

---
 rtl/object_draw_engine.sv | 169 ++++++++++++++++
 tb/tb_object_draw_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/object_draw_engine.sv
// Object draw engine: scans the selected object's rectangle and emits one VGA
// pixel write per clock, then pulses a one-hot done back to the sequencer.
module object_draw_engine #(
    parameter int             SCREEN_W      = 160,
    parameter int             SCREEN_H      = 120,
    parameter int             SPR_W         = 8,
    parameter int             SPR_H         = 8,
    parameter logic [2:0]     PLAYER_COLOUR = 3'b010,
    parameter logic [2:0]     ENEMY_COLOUR  = 3'b100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw_req,
    input  logic [3:0]  object_sel,
    input  logic [14:0] player_xy,
    input  logic [74:0] enemy_xy,
    output logic [14:0] rom_addr,
    input  logic [2:0]  rom_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic [8:0]  done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]  r_state;
    logic [3:0]  r_sel;
    logic [7:0]  r_ox;
    logic [6:0]  r_oy;
    logic [7:0]  r_wm1;
    logic [6:0]  r_hm1;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_rom;
    logic [8:0]  r_done;

    logic [14:0] w_xy;
    logic [8:0]  w_px;
    logic [7:0]  w_py;
    logic        w_inb;
    logic        w_last;
    logic        w_is_rom;
    logic [2:0]  w_colour;

    always_comb begin
        w_xy = '0;
        case (object_sel)
            4'd0:    w_xy = enemy_xy[14:0];
            4'd1:    w_xy = enemy_xy[29:15];
            4'd2:    w_xy = enemy_xy[44:30];
            4'd3:    w_xy = enemy_xy[59:45];
            4'd4:    w_xy = enemy_xy[74:60];
            4'd5:    w_xy = player_xy;
            default: w_xy = '0;
        endcase
    end

    // Widened sums so sprites near the right/bottom edge clip rather than wrap.
    assign w_px     = {1'b0, r_ox} + {1'b0, r_cx};
    assign w_py     = {1'b0, r_oy} + {1'b0, r_cy};
    assign w_inb    = (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));
    assign w_last   = (r_cx == r_wm1) && (r_cy == r_hm1);
    assign w_is_rom = (r_sel == 4'd6) || (r_sel == 4'd7);

    always_comb begin
        w_colour = 3'b000;
        if (r_sel < 4'd5)
            w_colour = ENEMY_COLOUR;
        else if (r_sel == 4'd5)
            w_colour = PLAYER_COLOUR;
    end

    assign rom_addr = (r_state == S_SCAN && w_is_rom)
                    ? 15'(w_py) * 15'(SCREEN_W) + 15'(w_px)
                    : 15'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_wm1    <= '0;
            r_hm1    <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_rom    <= 1'b0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            r_plot <= 1'b0;
            r_rom  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (draw_req)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sel <= object_sel;
                    r_cx  <= '0;
                    r_cy  <= '0;
                    if (object_sel <= 4'd5) begin
                        r_ox    <= w_xy[14:7];
                        r_oy    <= w_xy[6:0];
                        r_wm1   <= 8'(SPR_W - 1);
                        r_hm1   <= 7'(SPR_H - 1);
                        r_state <= S_SCAN;
                    end else if (object_sel <= 4'd8) begin
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_wm1   <= 8'(SCREEN_W - 1);
                        r_hm1   <= 7'(SCREEN_H - 1);
                        r_state <= S_SCAN;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_SCAN: begin
                    r_x      <= w_px[7:0];
                    r_y      <= w_py[6:0];
                    r_colour <= w_colour;
                    r_plot   <= w_inb;
                    r_rom    <= w_is_rom;
                    if (r_cx == r_wm1) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                    if (w_last)
                        r_state <= S_FLUSH;
                end
                S_FLUSH: r_state <= S_DONE;
                S_DONE: begin
                    r_done  <= 9'd1 << r_sel;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!draw_req)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ROM images arrive one cycle after the address, aligned with stage 1.
    assign colour = r_rom ? rom_data : r_colour;
    assign x      = r_x;
    assign y      = r_y;
    assign plot   = r_plot;
    assign done   = r_done;

endmodule

// File: tb/tb_object_draw_engine.sv
// Directed bench for object_draw_engine: sprite, full-screen, ROM, clipping,
// re-trigger blocking and reset-abort cases with hand-derived expectations.
module tb_object_draw_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        draw_req;
    logic [3:0]  object_sel;
    logic [14:0] player_xy;
    logic [74:0] enemy_xy;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data = 3'b000;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [8:0]  done;

    int total = 0;
    int bad   = 0;

    int nplot, bpix, first, dat, dcnt;
    logic [8:0] dval;

    object_draw_engine dut (
        .clk        (clk),
        .reset      (reset),
        .draw_req   (draw_req),
        .object_sel (object_sel),
        .player_xy  (player_xy),
        .enemy_xy   (enemy_xy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[2:0];

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raises draw_req at a negedge; n counts negedges after the sampling edge.
    task automatic run_scan(input logic [3:0] sel);
        int s, ox, oy, w, h, nn, k, ex, ey;
        logic inb;
        logic [2:0] ec;
        s = int'(sel);
        ox = 0; oy = 0; w = 160; h = 120;
        if (s <= 4) begin
            ox = int'(enemy_xy[s*15+7 +: 8]);
            oy = int'(enemy_xy[s*15 +: 7]);
            w = 8; h = 8;
        end else if (s == 5) begin
            ox = int'(player_xy[14:7]);
            oy = int'(player_xy[6:0]);
            w = 8; h = 8;
        end
        nn = (s <= 8) ? w * h : 0;
        nplot = 0; bpix = 0; first = -1; dat = -1; dcnt = 0; dval = '0;
        object_sel = sel;
        draw_req   = 1'b1;
        for (int n = 0; n < nn + 10; n++) begin
            step();
            if (plot) begin
                nplot++;
                if (first < 0) first = n;
            end
            if (done != 0) begin
                dcnt++;
                if (dat < 0) begin
                    dat  = n;
                    dval = done;
                end
            end
            k = n - 2;
            if (k >= 0 && k < nn) begin
                ex  = ox + k % w;
                ey  = oy + k / w;
                inb = (ex < 160) && (ey < 120);
                if (s <= 4)      ec = 3'b100;
                else if (s == 5) ec = 3'b010;
                else if (s == 8) ec = 3'b000;
                else             ec = 3'((ey * 160 + ex) % 8);
                if (plot !== inb)
                    bpix++;
                else if (inb && (x !== 8'(ex) || y !== 7'(ey) || colour !== ec))
                    bpix++;
            end else if (plot !== 1'b0) begin
                bpix++;
            end
        end
    endtask

    task automatic idle_gap();
        draw_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        int extra_p, extra_d;
        reset      = 1'b1;
        draw_req   = 1'b0;
        object_sel = 4'd0;
        player_xy  = {8'd10, 7'd20};
        enemy_xy   = '0;
        repeat (3) step();
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
        step();

        run_scan(4'd5);
        chk("player_plots", nplot, 64);
        chk("player_pixels", bpix, 0);
        chk("player_first", first, 2);
        chk("player_done_at", dat, 67);
        chk("player_done_val", int'(dval), 32'h020);
        chk("player_done_cnt", dcnt, 1);

        extra_p = 0; extra_d = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (plot) extra_p++;
            if (done != 0) extra_d++;
        end
        chk("hold_no_plot", extra_p, 0);
        chk("hold_no_done", extra_d, 0);
        idle_gap();
        run_scan(4'd5);
        chk("retrig_plots", nplot, 64);
        chk("retrig_done_cnt", dcnt, 1);
        idle_gap();

        run_scan(4'd8);
        chk("erase_plots", nplot, 19200);
        chk("erase_pixels", bpix, 0);
        chk("erase_done_val", int'(dval), 32'h100);
        chk("erase_done_cnt", dcnt, 1);
        chk("erase_done_at", dat, 19203);
        idle_gap();

        run_scan(4'd6);
        chk("rom_plots", nplot, 19200);
        chk("rom_pixels", bpix, 0);
        chk("rom_done_val", int'(dval), 32'h040);
        idle_gap();

        enemy_xy[44:30] = {8'd156, 7'd116};
        run_scan(4'd2);
        chk("clip_plots", nplot, 16);
        chk("clip_pixels", bpix, 0);
        chk("clip_done_val", int'(dval), 32'h004);
        idle_gap();

        object_sel = 4'd5;
        draw_req   = 1'b1;
        for (int n = 0; n <= 31; n++) step();
        chk("pre_abort_plot", int'(plot), 1);
        reset    = 1'b1;
        draw_req = 1'b0;
        step();
        chk("abort_plot", int'(plot), 0);
        chk("abort_done", int'(done), 0);
        step();
        reset = 1'b0;
        extra_d = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done != 0 || plot) extra_d++;
        end
        chk("abort_quiet", extra_d, 0);

        run_scan(4'd9);
        chk("sel9_plots", nplot, 0);
        chk("sel9_done_cnt", dcnt, 0);
        idle_gap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
